// File: rtl/soft_start_ramp_pkg.sv
// Shared definitions for the soft-start ramp and its neighbouring PWM-path blocks.
package soft_start_ramp_pkg;

  localparam int unsigned TON_W_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } ss_state_e;

endpackage

// File: rtl/soft_start_ramp_tick_gen.sv
// Free-running PRESCALE counter with synchronous clear; pulses tick_c for one cycle per period.
module ss_tick_gen #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = !clr && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/soft_start_ramp.sv
// Slew-limited on-time command: ramps o_ton from 0 to the target at STEP per PRESCALE cycles.
module soft_start_ramp
  import soft_start_ramp_pkg::*;
#(
  parameter int unsigned TON_W    = TON_W_DEF,
  parameter int unsigned STEP     = 1,
  parameter int unsigned PRESCALE = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [TON_W-1:0] i_ton_target,
  output logic [TON_W-1:0] o_ton,
  output logic             o_ramping,
  output logic             o_done
);

  localparam int unsigned SUM_W = TON_W + 1;

  ss_state_e        state_q, state_d;
  logic [TON_W-1:0] ton_q, ton_d;
  logic             ramping_q, ramping_d;
  logic             done_q, done_d;
  logic             tick_c;
  logic             tick_clr_c;
  logic [SUM_W-1:0] sum_c;

  // Prescaler only runs while actively ramping.
  assign tick_clr_c = (state_q != ST_RAMP) || !enable;

  ss_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (tick_clr_c),
    .tick_c(tick_c)
  );

  // One extra bit so a large STEP near full scale cannot wrap.
  assign sum_c = {1'b0, ton_q} + SUM_W'(STEP);

  always_comb begin
    state_d = state_q;
    ton_d   = ton_q;
    case (state_q)
      ST_IDLE: begin
        ton_d = '0;
        if (enable) begin
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (i_ton_target <= ton_q) begin
          ton_d   = i_ton_target;
          state_d = ST_HOLD;
        end else if (tick_c) begin
          if (sum_c >= {1'b0, i_ton_target}) begin
            ton_d   = i_ton_target;
            state_d = ST_HOLD;
          end else begin
            ton_d = sum_c[TON_W-1:0];
          end
        end
      end
      ST_HOLD: begin
        if (i_ton_target < ton_q) begin
          ton_d = i_ton_target;
        end else if (i_ton_target > ton_q) begin
          state_d = ST_RAMP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ton_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      ton_d   = '0;
    end
    ramping_d = (state_d == ST_RAMP);
    done_d    = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ton_q     <= '0;
      ramping_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ton_q     <= ton_d;
      ramping_q <= ramping_d;
      done_q    <= done_d;
    end
  end

  assign o_ton     = ton_q;
  assign o_ramping = ramping_q;
  assign o_done    = done_q;

endmodule
